seg7_scan: RTL and testbench

Parametrised multiplexed seven-segment display driver: time-multiplexes DIGITS hexadecimal digits onto one shared active-low cathode bus with per-digit enable, decimal point and blink, leading-zero suppression, and PWM brightness. Display inputs are captured once per scan frame, so a value never changes mid-frame. Sits between the calculator datapath/result registers and the board's anode/cathode pins, replacing the fixed 4-digit scanner.

---
 rtl/seg7_scan_if.sv | 26 ++
 rtl/seg7_scan.sv | 153 +++++++++++++++
 tb/tb_seg7_scan.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display-side bundle for seg7_scan: digit data and controls in, anode/cathode drive out.
// The master drives the digit data, the slave is the scanner.
interface seg7_scan_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blink;
    logic                lzs;
    logic [BRIGHT_W-1:0] bright;
    logic [6:0]          seg;
    logic                dp_n;
    logic [DIGITS-1:0]   an;

    modport master (
        output num, en, dp, blink, lzs, bright,
        input  seg, dp_n, an
    );

    modport slave (
        input  num, en, dp, blink, lzs, bright,
        output seg, dp_n, an
    );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner with per-frame input capture, leading-zero
// suppression, per-digit blink and PWM brightness. All drive outputs are registered.
module seg7_scan #(
    parameter int DIGITS     = 4,
    parameter int DIV_LOG2   = 16,
    parameter int BRIGHT_W   = 4,
    parameter int BLINK_LOG2 = 5
) (
    input  logic         clk,
    input  logic         rst,
    seg7_scan_if.slave   bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_LOG2-1:0]   cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [BLINK_LOG2:0]   frame_reg;

    logic [4*DIGITS-1:0]   num_sh_reg;
    logic [DIGITS-1:0]     en_sh_reg;
    logic [DIGITS-1:0]     dp_sh_reg;
    logic [DIGITS-1:0]     blink_sh_reg;
    logic                  lzs_sh_reg;

    logic [6:0]            seg_reg, seg_next;
    logic                  dp_n_reg, dp_n_next;
    logic [DIGITS-1:0]     an_reg, an_next;

    logic                  tick;
    logic                  frame_wrap;
    logic                  blink_off;

    assign tick       = &cnt_reg;
    assign frame_wrap = tick && (idx_reg == LAST_IDX);
    assign blink_off  = frame_reg[BLINK_LOG2];

    // Timebase: prescaler, digit index and frame counter all step on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            frame_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (tick) begin
                idx_reg <= frame_wrap ? '0 : idx_reg + 1'b1;
            end
            if (frame_wrap) begin
                frame_reg <= frame_reg + 1'b1;
            end
        end
    end

    // Shadow copy loads only at the frame wrap so a frame is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_sh_reg   <= '0;
            en_sh_reg    <= '0;
            dp_sh_reg    <= '0;
            blink_sh_reg <= '0;
            lzs_sh_reg   <= 1'b0;
        end else if (frame_wrap) begin
            num_sh_reg   <= bus.num;
            en_sh_reg    <= bus.en;
            dp_sh_reg    <= bus.dp;
            blink_sh_reg <= bus.blink;
            lzs_sh_reg   <= bus.lzs;
        end
    end

    logic [3:0]        nib [DIGITS];
    logic [DIGITS:1]   zero_above;
    logic [DIGITS-1:0] supp;

    assign zero_above[DIGITS] = 1'b1;

    // zero_above[i]: digit i and every digit above it show nothing (nibble 0, no dp).
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi] = num_sh_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign supp[gi] = 1'b0;
            end else begin : g_upper
                assign zero_above[gi] = zero_above[gi+1] & (nib[gi] == 4'h0) & ~dp_sh_reg[gi];
                assign supp[gi]       = lzs_sh_reg & zero_above[gi];
            end
        end
    endgenerate

    logic [3:0]          cur_nib;
    logic [6:0]          seg_code;
    logic [BRIGHT_W-1:0] phase;
    logic                lit;

    always_comb begin
        seg_code = 7'h7F;
        case (cur_nib)
            4'h0: seg_code = 7'h40;
            4'h1: seg_code = 7'h79;
            4'h2: seg_code = 7'h24;
            4'h3: seg_code = 7'h30;
            4'h4: seg_code = 7'h19;
            4'h5: seg_code = 7'h12;
            4'h6: seg_code = 7'h02;
            4'h7: seg_code = 7'h78;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h10;
            4'hA: seg_code = 7'h08;
            4'hB: seg_code = 7'h03;
            4'hC: seg_code = 7'h27;
            4'hD: seg_code = 7'h21;
            4'hE: seg_code = 7'h06;
            4'hF: seg_code = 7'h0E;
            default: seg_code = 7'h7F;
        endcase
    end

    // PWM: the top bits of the prescaler act as the slot phase, so the tail of each
    // slot is always dark and consecutive anodes never overlap.
    always_comb begin
        cur_nib   = nib[idx_reg];
        phase     = cnt_reg[DIV_LOG2-1 -: BRIGHT_W];
        lit       = en_sh_reg[idx_reg] & ~supp[idx_reg]
                  & ~(blink_sh_reg[idx_reg] & blink_off)
                  & (phase < bus.bright);
        an_next   = '1;
        seg_next  = 7'h7F;
        dp_n_next = 1'b1;
        if (lit) begin
            an_next   = ~(DIGITS'(1) << idx_reg);
            seg_next  = seg_code;
            dp_n_next = ~dp_sh_reg[idx_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg   <= '1;
            seg_reg  <= 7'h7F;
            dp_n_reg <= 1'b1;
        end else begin
            an_reg   <= an_next;
            seg_reg  <= seg_next;
            dp_n_reg <= dp_n_next;
        end
    end

    assign bus.an   = an_reg;
    assign bus.seg  = seg_reg;
    assign bus.dp_n = dp_n_reg;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed vector table, hand-written multi-frame sequences and
// randomized inputs checked every cycle against a frame/slot arithmetic reference model.
module tb_seg7_scan;
    localparam int DIGITS     = 4;
    localparam int DIV_LOG2   = 4;
    localparam int BRIGHT_W   = 2;
    localparam int BLINK_LOG2 = 1;
    localparam int SLOT       = 1 << DIV_LOG2;
    localparam int FRAME      = DIGITS * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

    seg7_scan #(
        .DIGITS(DIGITS), .DIV_LOG2(DIV_LOG2), .BRIGHT_W(BRIGHT_W), .BLINK_LOG2(BLINK_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n     = 0;

    logic [15:0] sh_num;
    logic [3:0]  sh_en, sh_dp, sh_blink;
    logic        sh_lzs;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        string       name;
        logic [15:0] num;
        logic [3:0]  en;
        logic [3:0]  dp;
        logic        lzs;
        logic [1:0]  bright;
        int          slot;
        int          c;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpn;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected drive for the decision made in cycle p of the run (p counted from reset release).
    task automatic model_out(input int p, output logic [3:0] a, output logic [6:0] s,
                             output logic d);
        int c, slot, frame, phase, top;
        logic lit;
        c     = p % SLOT;
        slot  = (p / SLOT) % DIGITS;
        frame = p / FRAME;
        phase = c >> (DIV_LOG2 - BRIGHT_W);
        top   = 0;
        for (int i = 0; i < DIGITS; i++)
            if (sh_num[4*i +: 4] != 4'h0 || sh_dp[i]) top = i;
        lit = sh_en[slot] && !(sh_lzs && slot > top)
              && !(sh_blink[slot] && ((frame >> BLINK_LOG2) & 1) == 1)
              && phase < int'(bus.bright);
        a = '1;
        s = 7'h7F;
        d = 1'b1;
        if (lit) begin
            a[slot] = 1'b0;
            s = dec_tab[sh_num[4*slot +: 4]];
            d = !sh_dp[slot];
        end
    endtask

    task automatic cyc();
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        model_out(n, ea, es, ed);
        @(posedge clk);
        n++;
        if (n % FRAME == 0) begin
            sh_num   = bus.num;
            sh_en    = bus.en;
            sh_dp    = bus.dp;
            sh_blink = bus.blink;
            sh_lzs   = bus.lzs;
        end
        @(negedge clk);
        check("model", {20'd0, bus.an, bus.seg, bus.dp_n}, {20'd0, ea, es, ed});
    endtask

    task automatic sync_frame();
        cyc();
        while (n % FRAME != 0) cyc();
    endtask

    task automatic run_to(input int slot, input int c);
        int target;
        target = slot * SLOT + c;
        for (int i = 0; i < FRAME && ((n - 1) % FRAME) != target; i++) cyc();
    endtask

    task automatic set_in(input logic [15:0] num, input logic [3:0] en, input logic [3:0] dp,
                          input logic [3:0] blink, input logic lzs, input logic [1:0] bright);
        bus.num    = num;
        bus.en     = en;
        bus.dp     = dp;
        bus.blink  = blink;
        bus.lzs    = lzs;
        bus.bright = bright;
    endtask

    task automatic clear_model();
        n        = 0;
        sh_num   = '0;
        sh_en    = '0;
        sh_dp    = '0;
        sh_blink = '0;
        sh_lzs   = 1'b0;
    endtask

    function automatic vec_t mk(input string name, input logic [15:0] num, input logic [3:0] en,
                                input logic [3:0] dp, input logic lzs, input logic [1:0] bright,
                                input int slot, input int c, input logic [3:0] an,
                                input logic [6:0] seg, input logic dpn);
        vec_t v;
        v.name = name; v.num = num; v.en = en; v.dp = dp; v.lzs = lzs; v.bright = bright;
        v.slot = slot; v.c = c; v.an = an; v.seg = seg; v.dpn = dpn;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo_cnt;
        int dig_lo [DIGITS];
        int f;

        vecs[0]  = mk("s0_lit",      16'h1234, 4'hF, 4'h0, 1'b0, 2'd3, 0, 0,  4'b1110, 7'h19, 1'b1);
        vecs[1]  = mk("s0_phase3",   16'h1234, 4'hF, 4'h0, 1'b0, 2'd3, 0, 12, 4'b1111, 7'h7F, 1'b1);
        vecs[2]  = mk("s3_lit",      16'h1234, 4'hF, 4'h0, 1'b0, 2'd3, 3, 0,  4'b0111, 7'h79, 1'b1);
        vecs[3]  = mk("s1_lit",      16'h1234, 4'hF, 4'h0, 1'b0, 2'd3, 1, 5,  4'b1101, 7'h30, 1'b1);
        vecs[4]  = mk("lzs_d3",      16'h0070, 4'hF, 4'h0, 1'b1, 2'd3, 3, 0,  4'b1111, 7'h7F, 1'b1);
        vecs[5]  = mk("lzs_d2",      16'h0070, 4'hF, 4'h0, 1'b1, 2'd3, 2, 2,  4'b1111, 7'h7F, 1'b1);
        vecs[6]  = mk("lzs_d1",      16'h0070, 4'hF, 4'h0, 1'b1, 2'd3, 1, 0,  4'b1101, 7'h78, 1'b1);
        vecs[7]  = mk("lzs_d0",      16'h0070, 4'hF, 4'h0, 1'b1, 2'd3, 0, 0,  4'b1110, 7'h40, 1'b1);
        vecs[8]  = mk("lzs0_d1",     16'h0000, 4'hF, 4'h0, 1'b1, 2'd3, 1, 0,  4'b1111, 7'h7F, 1'b1);
        vecs[9]  = mk("lzs_dp_d2",   16'h0000, 4'hF, 4'h4, 1'b1, 2'd3, 2, 1,  4'b1011, 7'h40, 1'b0);
        vecs[10] = mk("lzs_dp_d1",   16'h0000, 4'hF, 4'h4, 1'b1, 2'd3, 1, 0,  4'b1101, 7'h40, 1'b1);
        vecs[11] = mk("lzs_dp_d3",   16'h0000, 4'hF, 4'h4, 1'b1, 2'd3, 3, 0,  4'b1111, 7'h7F, 1'b1);
        vecs[12] = mk("en_off_dp",   16'h1234, 4'hB, 4'h4, 1'b0, 2'd3, 2, 0,  4'b1111, 7'h7F, 1'b1);
        vecs[13] = mk("dp_d0",       16'h1234, 4'hF, 4'h1, 1'b0, 2'd3, 0, 3,  4'b1110, 7'h19, 1'b0);
        vecs[14] = mk("bright1_ph0", 16'h1234, 4'hF, 4'h0, 1'b0, 2'd1, 2, 3,  4'b1011, 7'h24, 1'b1);

        // Reset state
        set_in(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", {20'd0, bus.an, bus.seg, bus.dp_n}, {20'd0, 4'hF, 7'h7F, 1'b1});
        rst = 1'b0;
        $display("[TB] reset: an=%b seg=%h dp_n=%b", bus.an, bus.seg, bus.dp_n);

        // First frame after reset is dark even though inputs are already valid
        lo_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            if (bus.an != 4'hF) lo_cnt++;
        end
        check("first_frame_dark", lo_cnt, 0);
        $display("[TB] first frame: %0d lit cycles", lo_cnt);

        // Directed vector table
        for (int v = 0; v < 15; v++) begin
            set_in(vecs[v].num, vecs[v].en, vecs[v].dp, 4'h0, vecs[v].lzs, vecs[v].bright);
            sync_frame();
            run_to(vecs[v].slot, vecs[v].c);
            check(vecs[v].name, {20'd0, bus.an, bus.seg, bus.dp_n},
                  {20'd0, vecs[v].an, vecs[v].seg, vecs[v].dpn});
            $display("[TB] vec %0d %s: an=%b seg=%h dp_n=%b", v, vecs[v].name,
                     bus.an, bus.seg, bus.dp_n);
        end

        // Mid-frame input change stays invisible until the next frame
        set_in(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
        sync_frame();
        run_to(1, 2);
        bus.num = 16'hABCD;
        run_to(3, 0);
        check("midframe_old_d3", {25'd0, bus.seg}, {25'd0, 7'h79});
        run_to(0, 0);
        check("newframe_d0", {25'd0, bus.seg}, {25'd0, 7'h21});
        run_to(1, 0);
        check("newframe_d1", {25'd0, bus.seg}, {25'd0, 7'h27});
        run_to(2, 0);
        check("newframe_d2", {25'd0, bus.seg}, {25'd0, 7'h03});
        run_to(3, 0);
        check("newframe_d3", {25'd0, bus.seg}, {25'd0, 7'h08});
        $display("[TB] midframe change: next frame d3 seg=%h", bus.seg);

        // Blink on digit 1: dark when frame counter mod 4 is 2 or 3
        set_in(16'h1234, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd3);
        sync_frame();
        for (int k = 0; k < 8; k++) begin
            run_to(0, 0);
            f = (n - 1) / FRAME;
            check("blink_d0", {28'd0, bus.an}, {28'd0, 4'b1110});
            run_to(1, 0);
            if ((f % 4) >= 2)
                check("blink_d1_off", {24'd0, bus.an, bus.seg[3:0]}, {24'd0, 4'hF, 4'hF});
            else
                check("blink_d1_on", {24'd0, bus.an, bus.seg[3:0]}, {24'd0, 4'b1101, 4'h0});
            $display("[TB] blink frame %0d: d1 an=%b", f, bus.an);
        end

        // Brightness 0 then 1
        set_in(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0);
        lo_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            if (bus.an != 4'hF) lo_cnt++;
        end
        check("bright0_dark", lo_cnt, 0);
        $display("[TB] bright=0: %0d lit cycles", lo_cnt);
        bus.bright = 2'd1;
        for (int d = 0; d < DIGITS; d++) dig_lo[d] = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            for (int d = 0; d < DIGITS; d++) if (bus.an[d] == 1'b0) dig_lo[d]++;
        end
        for (int d = 0; d < DIGITS; d++) check("bright1_duty", dig_lo[d], 4);
        $display("[TB] bright=1: duty %0d %0d %0d %0d", dig_lo[0], dig_lo[1], dig_lo[2], dig_lo[3]);

        // Asynchronous reset mid-slot 2
        bus.bright = 2'd3;
        sync_frame();
        run_to(2, 1);
        check("pre_rst_lit", {28'd0, bus.an}, {28'd0, 4'b1011});
        #2 rst = 1'b1;
        #1;
        check("async_rst", {20'd0, bus.an, bus.seg, bus.dp_n}, {20'd0, 4'hF, 7'h7F, 1'b1});
        $display("[TB] async reset: an=%b seg=%h dp_n=%b", bus.an, bus.seg, bus.dp_n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        lo_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            if (bus.an != 4'hF) lo_cnt++;
        end
        check("post_rst_dark", lo_cnt, 0);
        run_to(0, 0);
        check("post_rst_frame2", {20'd0, bus.an, bus.seg, bus.dp_n}, {20'd0, 4'b1110, 7'h19, 1'b1});
        $display("[TB] after reset: dark frame %0d lit, frame 2 an=%b seg=%h", lo_cnt, bus.an, bus.seg);

        // Randomized inputs checked every cycle by the model
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                set_in(16'($urandom_range(0, 65535) >> $urandom_range(0, 16)),
                       4'($urandom), 4'($urandom & $urandom), 4'($urandom & $urandom),
                       1'($urandom), 2'($urandom));
                $display("[TB] rand: num=%h en=%b dp=%b blink=%b lzs=%b bright=%0d",
                         bus.num, bus.en, bus.dp, bus.blink, bus.lzs, bus.bright);
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
